// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: AXI4-Stream byte input, FIFO queue, 8-bit frames with
// optional parity and 1 or 2 stop bits. tx_bit is driven straight from a flop.
module uart_tx_buffered #(
    parameter int unsigned CLOCK_FREQ_HZ = 125_000_000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          s_axis_tvalid,
    input  logic [7:0]                    s_axis_tdata,
    output logic                          s_axis_tready,
    input  logic                          cts,
    output logic                          tx_bit,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CYCLES_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
    localparam int unsigned CNT_W          = $clog2(STOP_CYCLES);
    localparam int unsigned AW             = $clog2(FIFO_DEPTH);
    localparam int unsigned CW             = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             par_bit;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             push_c;
    logic             pop_c;
    logic [CW-1:0]    count_next_c;
    logic [7:0]       head_c;
    logic             bit_end_c;
    logic             line_c;

    assign push_c       = s_axis_tvalid && s_axis_tready;
    assign pop_c        = (state == ST_IDLE) && (fifo_count != '0) && cts;
    assign count_next_c = fifo_count + CW'(push_c) - CW'(pop_c);
    assign head_c       = mem[rd_ptr];
    assign bit_end_c    = (baud_cnt == CNT_W'(CYCLES_PER_BIT - 1));

    // Line level for the current state; registered into tx_bit one cycle later.
    always_comb begin
        line_c = 1'b1;
        case (state)
            ST_START: line_c = 1'b0;
            ST_DATA:  line_c = shreg[bit_idx];
            ST_PAR:   line_c = par_bit;
            default:  line_c = 1'b1;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (push_c) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    // tready is precomputed from the post-edge count so it tracks !full exactly.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count    <= count_next_c;
            s_axis_tready <= (count_next_c != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_bit   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            tx_bit <= line_c;
            busy   <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop_c) begin
                        shreg   <= head_c;
                        par_bit <= (^head_c) ^ (PARITY == 2);
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= (PARITY == 0) ? ST_STOP : ST_PAR;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_PAR: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == CNT_W'(STOP_CYCLES - 1)) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
